gradient_arbiter: RTL and testbench

Round-robin, packet-locked arbiter that shares one image-gradient/CORDIC datapath between two requesters, e.g. orientation assignment and descriptor sampling. Each requester streams 4-neighbour pixel packets; the arbiter forwards one packet at a time to the gradient unit. It tags every sample with a matching-latency delay line and routes each magnitude/orientation result back to the requester that issued it. The block sits between the keypoint-window readers and the gradient unit in the SIFT descriptor path.

---
 rtl/grad_arb_pkg.sv | 11 +
 rtl/grad_tag_pipe.sv | 25 ++
 rtl/gradient_arbiter.sv | 106 ++++++++++
 tb/tb_gradient_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_arb_pkg.sv
// grad_arb_pkg: shared types and widths for the gradient arbiter slice
package grad_arb_pkg;
  localparam int PIX_W = 9;
  localparam int RES_W = 16;
  typedef enum logic {IDLE, LOCK} state_t;
  typedef struct packed {
    logic valid;
    logic id;
    logic last;
  } tag_t;
endpackage

// File: rtl/grad_tag_pipe.sv
// grad_tag_pipe: GRAD_LAT-stage shift register carrying request tags alongside the gradient unit
//   iclk/ireset  clock, async active-low reset (clears every stage)
//   itag         tag entering stage 0
//   otag         tag leaving stage GRAD_LAT-1
module grad_tag_pipe
  import grad_arb_pkg::*;
#(
  parameter int GRAD_LAT = 14
) (
  input  logic iclk,
  input  logic ireset,
  input  tag_t itag,
  output tag_t otag
);
  tag_t r_pipe [GRAD_LAT];
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      for (int i = 0; i < GRAD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= itag;
      for (int i = 1; i < GRAD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign otag = r_pipe[GRAD_LAT-1];
endmodule

// File: rtl/gradient_arbiter.sv
// gradient_arbiter: round-robin packet-locked arbiter sharing one gradient unit between two requesters
//   iclk/ireset         clock, async active-low reset
//   ireq_*/oreq_ready   requester sample streams and one-hot accept
//   ogrd_*              registered samples to the gradient unit
//   igrd_*              results from the gradient unit, GRAD_LAT cycles after ogrd_en
//   ores_*              results routed back to the issuing requester
//   obusy/oerr          activity flag and sticky tag/result misalignment
module gradient_arbiter
  import grad_arb_pkg::*;
#(
  parameter int GRAD_LAT = 14,
  parameter int CNT_W = 5
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic [1:0]         ireq_valid,
  input  logic [1:0]         ireq_last,
  input  logic [4*PIX_W-1:0] ireq0_pix,
  input  logic [4*PIX_W-1:0] ireq1_pix,
  output logic [1:0]         oreq_ready,
  output logic               ogrd_en,
  output logic [PIX_W-1:0]   ogrd_top,
  output logic [PIX_W-1:0]   ogrd_left,
  output logic [PIX_W-1:0]   ogrd_right,
  output logic [PIX_W-1:0]   ogrd_bot,
  input  logic [RES_W-1:0]   igrd_mag,
  input  logic [RES_W-1:0]   igrd_ori,
  input  logic               igrd_en,
  output logic [1:0]         ores_valid,
  output logic               ores_last,
  output logic [RES_W-1:0]   ores_mag,
  output logic [RES_W-1:0]   ores_ori,
  output logic               obusy,
  output logic               oerr
);
  state_t r_state, w_next;
  logic r_owner, r_ptr, r_grd_en, r_grd_id, r_grd_last, r_last, r_err;
  logic [1:0] r_res_valid;
  logic [4*PIX_W-1:0] r_pix;
  logic [RES_W-1:0] r_mag, r_ori;
  logic [CNT_W-1:0] r_cnt;
  logic w_xfer, w_done, w_win, w_strobe;
  tag_t w_tag_in, w_tag;
  assign w_xfer = (r_state == LOCK) & ireq_valid[r_owner];
  assign w_done = w_xfer & ireq_last[r_owner];
  // r_ptr names the requester that wins a tie; a lone requester always wins
  assign w_win = &ireq_valid ? r_ptr : ireq_valid[1];
  assign w_strobe = igrd_en & w_tag.valid;
  assign w_tag_in = '{valid: r_grd_en, id: r_grd_id, last: r_grd_last};
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (|ireq_valid ? LOCK : IDLE) : (w_done ? IDLE : LOCK);
  end
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_owner <= 1'b0;
      r_ptr <= 1'b0;
      r_grd_en <= 1'b0;
      r_grd_id <= 1'b0;
      r_grd_last <= 1'b0;
      r_pix <= '0;
      r_res_valid <= '0;
      r_last <= 1'b0;
      r_mag <= '0;
      r_ori <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && |ireq_valid) r_owner <= w_win;
      if (w_done) r_ptr <= ~r_owner;
      r_grd_en <= w_xfer;
      if (w_xfer) begin
        r_pix <= r_owner ? ireq1_pix : ireq0_pix;
        r_grd_id <= r_owner;
        r_grd_last <= ireq_last[r_owner];
      end
      r_res_valid <= w_strobe ? (w_tag.id ? 2'b10 : 2'b01) : 2'b00;
      r_last <= w_strobe & w_tag.last;
      if (w_strobe) begin
        r_mag <= igrd_mag;
        r_ori <= igrd_ori;
      end
      r_cnt <= r_cnt + CNT_W'(r_grd_en) - CNT_W'(|r_res_valid);
      if (igrd_en != w_tag.valid) r_err <= 1'b1;
    end
  end
  grad_tag_pipe #(.GRAD_LAT(GRAD_LAT)) u_tag_pipe (
    .iclk(iclk),
    .ireset(ireset),
    .itag(w_tag_in),
    .otag(w_tag)
  );
  assign oreq_ready = (r_state == LOCK) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign ogrd_en = r_grd_en;
  assign {ogrd_top, ogrd_left, ogrd_right, ogrd_bot} = r_pix;
  assign ores_valid = r_res_valid;
  assign ores_last = r_last;
  assign ores_mag = r_mag;
  assign ores_ori = r_ori;
  assign obusy = (r_state == LOCK) | (r_cnt != '0);
  assign oerr = r_err;
endmodule

// File: tb/tb_gradient_arbiter.sv
// tb_gradient_arbiter: scoreboard bench for gradient_arbiter with an echoing gradient-unit model
module tb_gradient_arbiter;
  localparam int LAT = 14;
  logic iclk = 1'b0;
  logic ireset = 1'b0;
  logic [1:0] ireq_valid = '0, ireq_last = '0;
  logic [35:0] ireq0_pix = '0, ireq1_pix = '0;
  logic [1:0] oreq_ready, ores_valid;
  logic ogrd_en, ores_last, obusy, oerr, igrd_en;
  logic [8:0] ogrd_top, ogrd_left, ogrd_right, ogrd_bot;
  logic [15:0] igrd_mag, igrd_ori, ores_mag, ores_ori;
  logic inj = 1'b0;
  logic [32:0] gp [LAT] = '{default: '0};
  typedef struct {
    bit id;
    bit last;
    logic [15:0] mag;
    logic [15:0] ori;
    int t;
  } exp_t;
  exp_t q[$];
  exp_t e_pop;
  logic [35:0] p_mon;
  int errs = 0, checks = 0, ncyc = 0;
  int nres [2] = '{0, 0};
  always #5 iclk = ~iclk;
  gradient_arbiter #(.GRAD_LAT(LAT), .CNT_W(5)) dut (
    .iclk(iclk), .ireset(ireset),
    .ireq_valid(ireq_valid), .ireq_last(ireq_last),
    .ireq0_pix(ireq0_pix), .ireq1_pix(ireq1_pix),
    .oreq_ready(oreq_ready), .ogrd_en(ogrd_en),
    .ogrd_top(ogrd_top), .ogrd_left(ogrd_left), .ogrd_right(ogrd_right), .ogrd_bot(ogrd_bot),
    .igrd_mag(igrd_mag), .igrd_ori(igrd_ori), .igrd_en(igrd_en),
    .ores_valid(ores_valid), .ores_last(ores_last),
    .ores_mag(ores_mag), .ores_ori(ores_ori),
    .obusy(obusy), .oerr(oerr)
  );
  function automatic logic [15:0] fold(input logic [8:0] a, input logic [8:0] b);
    return {a, 7'd0} ^ {7'd0, b};
  endfunction
  // gradient unit: echoes a fold of the pixels LAT cycles after ogrd_en; never reset
  always @(posedge iclk) begin
    gp[0] <= {ogrd_en, fold(ogrd_top, ogrd_left), fold(ogrd_right, ogrd_bot)};
    for (int i = 1; i < LAT; i++) gp[i] <= gp[i-1];
  end
  assign igrd_en = gp[LAT-1][32] | inj;
  assign igrd_mag = gp[LAT-1][31:16];
  assign igrd_ori = gp[LAT-1][15:0];
  always @(negedge iclk) begin
    ncyc++;
    if (!ireset) q.delete();
    else begin
      if (|ores_valid) begin
        checks++;
        if (ores_valid == 2'b11 || q.size() == 0) begin
          errs++;
          $display("FAIL result_unexpected: ores_valid=%b pending=%0d, required one-hot with a pending entry", ores_valid, q.size());
        end else begin
          e_pop = q.pop_front();
          nres[ores_valid[1]]++;
          if ({ores_valid[1], ores_last, ores_mag, ores_ori} !== {e_pop.id, e_pop.last, e_pop.mag, e_pop.ori} || ncyc - e_pop.t != 16) begin
            errs++;
            $display("FAIL result: got id=%b last=%b mag=%h ori=%h lat=%0d, want id=%b last=%b mag=%h ori=%h lat=16",
                     ores_valid[1], ores_last, ores_mag, ores_ori, ncyc - e_pop.t, e_pop.id, e_pop.last, e_pop.mag, e_pop.ori);
          end
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (ireq_valid[r] && oreq_ready[r]) begin
          p_mon = r[0] ? ireq1_pix : ireq0_pix;
          q.push_back('{id: r[0], last: ireq_last[r], mag: fold(p_mon[35:27], p_mon[26:18]),
                        ori: fold(p_mon[17:9], p_mon[8:0]), t: ncyc});
        end
      end
    end
  end
  task automatic cyc(input logic [1:0] v, input logic [1:0] l);
    @(posedge iclk);
    #1;
    ireq_valid = v;
    ireq_last = l;
    ireq0_pix = {4'($urandom), $urandom};
    ireq1_pix = {4'($urandom), $urandom};
    @(negedge iclk);
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while (obusy && n < 60) begin
      cyc(2'b00, 2'b00);
      n++;
    end
    checks++;
    if (obusy !== 1'b0 || q.size() != 0) begin
      errs++;
      $display("FAIL %s_drain: obusy=%b pending=%0d, want 0 and 0", nm, obusy, q.size());
    end
  endtask
  task automatic run_seq(input string nm, input int n, input logic [15:0] vs, input logic [15:0] ls, input logic [15:0] rs);
    for (int i = 0; i < n; i++) begin
      cyc(vs[2*i +: 2], ls[2*i +: 2]);
      checks++;
      if (oreq_ready !== rs[2*i +: 2]) begin
        errs++;
        $display("FAIL %s_ready_c%0d: oreq_ready=%b want %b", nm, i, oreq_ready, rs[2*i +: 2]);
      end
    end
  endtask
  task automatic test_reset();
    ireq_valid = 2'b11;
    #12;
    checks++;
    if ({oreq_ready, ogrd_en, ores_valid, ores_last, obusy, oerr} !== 7'd0) begin
      errs++;
      $display("FAIL reset_ctl: ready=%b en=%b res=%b last=%b busy=%b err=%b, want all 0", oreq_ready, ogrd_en, ores_valid, ores_last, obusy, oerr);
    end
    checks++;
    if ({ogrd_top, ogrd_left, ogrd_right, ogrd_bot, ores_mag, ores_ori} !== 68'd0) begin
      errs++;
      $display("FAIL reset_data: pix=%h mag=%h ori=%h, want 0", {ogrd_top, ogrd_left, ogrd_right, ogrd_bot}, ores_mag, ores_ori);
    end
    ireq_valid = 2'b00;
    @(posedge iclk);
    #1;
    ireset = 1'b1;
  endtask
  task automatic test_simultaneous();
    run_seq("simul", 6, {4'd0, 12'b11_11_11_11_11_11}, {4'd0, 12'b01_00_10_00_01_00}, {4'd0, 12'b01_00_10_00_01_00});
    cyc(2'b00, 2'b00);
    wait_idle("simul");
  endtask
  task automatic test_req0_only();
    int a0 = nres[0], a1 = nres[1];
    run_seq("req0", 6, {4'd0, 12'b00_01_01_01_01_01}, {4'd0, 12'b00_01_00_00_00_00}, {4'd0, 12'b00_01_01_01_01_00});
    wait_idle("req0");
    checks++;
    if (nres[0] - a0 != 4 || nres[1] - a1 != 0) begin
      errs++;
      $display("FAIL req0_counts: res0=%0d res1=%0d, want 4 and 0", nres[0] - a0, nres[1] - a1);
    end
  endtask
  task automatic test_hold_lock();
    for (int i = 0; i < 8; i++) begin
      logic [15:0] vs = 16'b10_10_11_10_10_10_01_01;
      logic [15:0] ls = 16'b10_00_01_00_00_00_00_00;
      logic [15:0] rs = 16'b10_00_01_01_01_01_01_00;
      cyc(vs[2*i +: 2], ls[2*i +: 2]);
      checks++;
      if (oreq_ready !== rs[2*i +: 2] || (i >= 2 && i <= 4 && obusy !== 1'b1)) begin
        errs++;
        $display("FAIL hold_c%0d: oreq_ready=%b obusy=%b, want %b and 1", i, oreq_ready, obusy, rs[2*i +: 2]);
      end
    end
    cyc(2'b00, 2'b00);
    wait_idle("hold");
  endtask
  task automatic test_back_to_back();
    int rem [2] = '{3, 5};
    int pk [2] = '{2, 2};
    int a0 = nres[0], a1 = nres[1];
    for (int n = 0; n < 200 && (pk[0] + pk[1]) > 0; n++) begin
      cyc({pk[1] > 0, pk[0] > 0}, {rem[1] == 1, rem[0] == 1});
      for (int r = 0; r < 2; r++) begin
        if (ireq_valid[r] && oreq_ready[r]) begin
          rem[r]--;
          if (rem[r] == 0) begin
            pk[r]--;
            rem[r] = r ? 1 : 2;
          end
        end
      end
    end
    checks++;
    if (pk[0] + pk[1] != 0) begin
      errs++;
      $display("FAIL b2b_timeout: packets left=%0d, want 0", pk[0] + pk[1]);
    end
    cyc(2'b00, 2'b00);
    wait_idle("b2b");
    checks++;
    if (nres[0] - a0 != 5 || nres[1] - a1 != 6) begin
      errs++;
      $display("FAIL b2b_counts: res0=%0d res1=%0d, want 5 and 6", nres[0] - a0, nres[1] - a1);
    end
  endtask
  task automatic test_spurious();
    logic [15:0] m = ores_mag;
    @(posedge iclk);
    #1;
    inj = 1'b1;
    @(posedge iclk);
    #1;
    inj = 1'b0;
    @(negedge iclk);
    checks++;
    if (oerr !== 1'b1 || ores_valid !== 2'b00 || ores_mag !== m) begin
      errs++;
      $display("FAIL spurious: oerr=%b ores_valid=%b mag=%h, want 1, 00, %h", oerr, ores_valid, ores_mag, m);
    end
    repeat (3) cyc(2'b00, 2'b00);
    checks++;
    if (oerr !== 1'b1) begin
      errs++;
      $display("FAIL spurious_sticky: oerr=%b want 1", oerr);
    end
  endtask
  task automatic test_reset_inflight();
    int a1;
    run_seq("rst_pkt", 6, {4'd0, 12'b01_01_01_01_01_01}, {4'd0, 12'b01_00_00_00_00_00}, {4'd0, 12'b01_01_01_01_01_00});
    cyc(2'b00, 2'b00);
    checks++;
    if (obusy !== 1'b1) begin
      errs++;
      $display("FAIL rst_busy: obusy=%b want 1", obusy);
    end
    @(posedge iclk);
    #1;
    ireset = 1'b0;
    #1;
    checks++;
    if ({oreq_ready, ogrd_en, ogrd_top, ogrd_left, ogrd_right, ogrd_bot, ores_valid, ores_last, ores_mag, ores_ori, obusy, oerr} !== 76'd0) begin
      errs++;
      $display("FAIL rst_async: ready=%b en=%b res=%b busy=%b err=%b mag=%h, want all 0", oreq_ready, ogrd_en, ores_valid, obusy, oerr, ores_mag);
    end
    repeat (2) @(posedge iclk);
    #1;
    ireset = 1'b1;
    repeat (25) cyc(2'b00, 2'b00);
    checks++;
    if (oerr !== 1'b1 || obusy !== 1'b0) begin
      errs++;
      $display("FAIL rst_stale: oerr=%b obusy=%b, want 1 and 0", oerr, obusy);
    end
    a1 = nres[1];
    run_seq("rst_after", 3, {10'd0, 6'b10_10_10}, {10'd0, 6'b10_00_00}, {10'd0, 6'b10_10_00});
    cyc(2'b00, 2'b00);
    wait_idle("rst_after");
    checks++;
    if (nres[1] - a1 != 2) begin
      errs++;
      $display("FAIL rst_after_count: res1=%0d want 2", nres[1] - a1);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_simultaneous();
    test_req0_only();
    test_hold_lock();
    test_back_to_back();
    test_spurious();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
